// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter
// Round-robin arbiter and sequencer for a shared snooping bus. One requester
// at a time is granted, its BusRd/BusRdX/BusUpgr is broadcast for one cycle,
// snoop responses from every other cache are collected over a fixed window,
// and the requester receives a done pulse with the aggregated shared flag.
//
// Build option: define COHERENCE_BUS_FLUSH_EN to add the flush_ack input and
// a FLUSH state that holds the grant until a dirty owner has written back.
module coherence_bus_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32,
    parameter int SNOOP_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CACHES-1:0]         req,
    input  logic [2*NUM_CACHES-1:0]       req_op,
    input  logic [ADDR_W*NUM_CACHES-1:0]  req_addr,
    output logic [NUM_CACHES-1:0]         gnt,
    output logic                          bus_valid,
    output logic [1:0]                    bus_op,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [$clog2(NUM_CACHES)-1:0] bus_src,
    input  logic [NUM_CACHES-1:0]         snoop_shared,
    input  logic [NUM_CACHES-1:0]         snoop_dirty,
    output logic [NUM_CACHES-1:0]         done,
    output logic                          done_shared,
    output logic                          busy
`ifdef COHERENCE_BUS_FLUSH_EN
    ,
    input  logic                          flush_ack
`endif
);

    localparam int SRC_W = $clog2(NUM_CACHES);
    localparam int SUM_W = SRC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SNOOP,
        S_DONE
`ifdef COHERENCE_BUS_FLUSH_EN
        ,
        S_FLUSH
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               shared_acc_q, shared_acc_d;
    logic               dirty_acc_q, dirty_acc_d;

    // Per-cache views of the packed request buses.
    logic [1:0]         op_arr   [NUM_CACHES];
    logic [ADDR_W-1:0]  addr_arr [NUM_CACHES];

    logic [SRC_W-1:0]      sel_idx;
    logic [NUM_CACHES-1:0] other_mask;
    logic                  active;

    assign active     = (state_q != S_IDLE);
    assign other_mask = ~(NUM_CACHES'(1) << src_q);

    generate
        for (genvar gi = 0; gi < NUM_CACHES; gi++) begin : g_cache
            localparam logic [SRC_W-1:0] IDX = SRC_W'(gi);
            assign op_arr[gi]   = req_op[2*gi +: 2];
            assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
            // Grant is held for the whole transaction, GRANT through DONE.
            assign gnt[gi]      = active && (src_q == IDX);
            assign done[gi]     = (state_q == S_DONE) && (src_q == IDX);
        end
    endgenerate

    // Round-robin pick: first requester at or after the pointer, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        logic [SUM_W-1:0] sum;
        sel_idx = '0;
        sum     = '0;
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_CACHES)) begin
                sum = sum - SUM_W'(NUM_CACHES);
            end
            if (req[sum[SRC_W-1:0]]) begin
                sel_idx = sum[SRC_W-1:0];
            end
        end
    end

    // Next-state logic for the transaction sequencer and its datapath.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        src_d        = src_q;
        op_d         = op_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        shared_acc_d = shared_acc_q;
        dirty_acc_d  = dirty_acc_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    src_d   = sel_idx;
                    // Op 11 is not a real transaction; it goes out as BusRd.
                    op_d    = (op_arr[sel_idx] == 2'b11) ? 2'b00 : op_arr[sel_idx];
                    addr_d  = addr_arr[sel_idx];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                shared_acc_d = 1'b0;
                dirty_acc_d  = 1'b0;
                cnt_d        = 4'(SNOOP_LAT);
                state_d      = S_SNOOP;
            end
            S_SNOOP: begin
                // The requester's own snoop bits never count.
                shared_acc_d = shared_acc_q | (|(snoop_shared & other_mask));
                dirty_acc_d  = dirty_acc_q  | (|(snoop_dirty  & other_mask));
                cnt_d        = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
`ifdef COHERENCE_BUS_FLUSH_EN
                    state_d = dirty_acc_d ? S_FLUSH : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef COHERENCE_BUS_FLUSH_EN
            S_FLUSH: begin
                if (flush_ack) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                ptr_d   = (src_q == SRC_W'(NUM_CACHES - 1)) ? '0 : src_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            src_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            shared_acc_q <= 1'b0;
            dirty_acc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            src_q        <= src_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            shared_acc_q <= shared_acc_d;
            dirty_acc_q  <= dirty_acc_d;
        end
    end

    // Bus outputs are decoded from state; the broadcast fields are only
    // driven while a transaction is in flight so IDLE shows a quiet bus.
    always_comb begin
        busy        = active;
        bus_valid   = (state_q == S_GRANT);
        bus_op      = active ? op_q   : '0;
        bus_addr    = active ? addr_q : '0;
        bus_src     = active ? src_q  : '0;
        done_shared = (state_q == S_DONE) && (shared_acc_q || dirty_acc_q);
    end

endmodule
